// File: rtl/aes_wb_regif.sv
// Wishbone slave register block that feeds an AES core with key/data, sequences
// a single operation through IDLE/LOAD/WAIT and captures the result.
module aes_wb_regif #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          KEY_W    = 128,
  parameter int          TIMEOUT  = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             irq_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [127:0]     core_data_o,
  output logic             core_en_o,
  output logic             core_ed_o,
  output logic             core_rst_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_data_i
);

  localparam int          KW       = KEY_W / 32;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        irq_q;
  logic        core_en_q;
  logic        core_rst_q;
  logic        ed_run_q;
  logic        ed_q;
  logic        irq_en_q;
  logic        done_q;
  logic        to_err_q;
  logic        wr_ign_q;
  logic [31:0] key_q  [8];
  logic [31:0] data_q [4];
  logic [31:0] res_q  [4];

  logic        in_win;
  logic        hit;
  logic        wr_en;
  logic [5:0]  widx;
  logic [2:0]  key_idx;
  logic        sel_ctrl;
  logic        sel_stat;
  logic        sel_key;
  logic        sel_data;
  logic        sel_res;
  logic        key_ok;
  logic        busy;
  logic        ctrl_wr;
  logic        soft_rst;
  logic        start_ok;
  logic        ign_wr;
  logic [2:0]  stat_clr;
  logic [31:0] rd_word;
  logic        unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
    return r;
  endfunction

  // The ~ack term throttles a held strobe to one transfer every two cycles.
  assign in_win   = wbs_adr_i[31:8] == BASE_ADR[31:8];
  assign hit      = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;
  assign wr_en    = hit & wbs_we_i;
  assign widx     = wbs_adr_i[7:2];
  assign key_idx  = widx[2:0];
  assign sel_ctrl = widx == 6'h00;
  assign sel_stat = widx == 6'h01;
  assign sel_key  = widx[5:3] == 3'b001;
  assign sel_data = widx[5:2] == 4'b0100;
  assign sel_res  = widx[5:2] == 4'b0110;
  assign key_ok   = int'(key_idx) < KW;
  assign busy     = state != IDLE;

  assign ctrl_wr  = wr_en & sel_ctrl & wbs_sel_i[0];
  assign soft_rst = ctrl_wr & wbs_dat_i[3];
  assign start_ok = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[3] & ~busy;
  assign stat_clr = (wr_en & sel_stat & wbs_sel_i[0]) ? wbs_dat_i[3:1] : 3'b000;

  // A CTRL write while busy is flagged only if it tries to start or change ED.
  assign ign_wr = wr_en & busy &
                  ((sel_key & key_ok & |wbs_sel_i) |
                   (sel_data & |wbs_sel_i) |
                   (ctrl_wr & ~wbs_dat_i[3] & (wbs_dat_i[0] | (wbs_dat_i[1] != ed_q))));

  always_comb begin
    rd_word = '0;
    if (sel_ctrl)              rd_word = {29'd0, irq_en_q, ed_q, 1'b0};
    else if (sel_stat)         rd_word = {28'd0, wr_ign_q, to_err_q, done_q, busy};
    else if (sel_key && key_ok) rd_word = key_q[key_idx];
    else if (sel_data)         rd_word = data_q[widx[1:0]];
    else if (sel_res)          rd_word = res_q[widx[1:0]];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= hit;
      dat_q <= (hit & ~wbs_we_i) ? rd_word : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else if (soft_rst) begin
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else if (wr_en & ~busy) begin
      if (sel_key & key_ok)
        key_q[key_idx] <= be_merge(key_q[key_idx], wbs_dat_i, wbs_sel_i);
      if (sel_data)
        data_q[widx[1:0]] <= be_merge(data_q[widx[1:0]], wbs_dat_i, wbs_sel_i);
    end
  end

  // W1C clears are assigned first so any hardware set later in the block wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      irq_q      <= 1'b0;
      core_en_q  <= 1'b0;
      core_rst_q <= 1'b1;
      ed_run_q   <= 1'b0;
      ed_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      to_err_q   <= 1'b0;
      wr_ign_q   <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      core_rst_q <= 1'b0;
      irq_q      <= irq_en_q & (done_q | to_err_q);
      if (ctrl_wr) irq_en_q <= wbs_dat_i[2];
      if (ctrl_wr & ~busy) ed_q <= wbs_dat_i[1];
      done_q   <= done_q   & ~stat_clr[0];
      to_err_q <= to_err_q & ~stat_clr[1];
      wr_ign_q <= wr_ign_q & ~stat_clr[2];
      if (ign_wr) wr_ign_q <= 1'b1;

      if (soft_rst) begin
        state      <= IDLE;
        cnt        <= '0;
        core_en_q  <= 1'b0;
        core_rst_q <= 1'b1;
        ed_run_q   <= 1'b0;
        done_q     <= 1'b0;
        to_err_q   <= 1'b0;
        wr_ign_q   <= 1'b0;
        for (int i = 0; i < 4; i++) res_q[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state      <= LOAD;
              done_q     <= 1'b0;
              to_err_q   <= 1'b0;
              ed_run_q   <= wbs_dat_i[1];
              core_rst_q <= 1'b1;
            end
          end
          LOAD: begin
            state     <= WAIT;
            cnt       <= '0;
            core_en_q <= 1'b1;
          end
          WAIT: begin
            if (core_done_i) begin
              for (int i = 0; i < 4; i++) res_q[i] <= core_data_i[127-32*i -: 32];
              done_q    <= 1'b1;
              core_en_q <= 1'b0;
              state     <= IDLE;
            end else if (cnt == CNT_LAST) begin
              to_err_q   <= 1'b1;
              core_rst_q <= 1'b1;
              core_en_q  <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < KW; i++) begin : g_key
    assign core_key_o[KEY_W-1-32*i -: 32] = key_q[i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_data
    assign core_data_o[127-32*i -: 32] = data_q[i];
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign irq_o      = irq_q;
  assign core_en_o  = core_en_q;
  assign core_ed_o  = ed_run_q;
  assign core_rst_o = core_rst_q;

endmodule
